// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE-754 single-precision subtractor, R = A - B.
// Ports: clk, rst_n (async low), start, data_a, data_b -> busy, done, data_r, overflow.
// Optional macro FP_SUB_SEQ_ROUND_EN adds a ROUND state (nearest-even); otherwise truncates.
module fp_sub_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] data_a,
   input  logic [31:0] data_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] data_r,
   output logic        overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADD,
      S_NORM,
`ifdef FP_SUB_SEQ_ROUND_EN
      S_ROUND,
`endif
      S_PACK,
      S_DONE
   } state_t;

`ifdef FP_SUB_SEQ_ROUND_EN
   localparam state_t S_POST = S_ROUND;
`else
   localparam state_t S_POST = S_PACK;
`endif

   state_t      state;
   logic        sx, sy;
   logic [7:0]  ex, ey;
   // {carry, hidden, frac[22:0], guard, round, sticky}
   logic [27:0] mx, my;
   logic        nan_q, ovf_q, flush_q;

   logic [7:0]  ea, eb, diff;
   logic [22:0] fa, fb;
   logic [27:0] ma, mb;
   logic        a_ge, nan_in;
   logic [26:0] sum_hi;

   assign ea     = data_a[30:23];
   assign eb     = data_b[30:23];
   assign fa     = (ea == 8'd0) ? 23'd0 : data_a[22:0];
   assign fb     = (eb == 8'd0) ? 23'd0 : data_b[22:0];
   assign ma     = {1'b0, ea != 8'd0, fa, 3'b000};
   assign mb     = {1'b0, eb != 8'd0, fb, 3'b000};
   assign a_ge   = {ea, fa} >= {eb, fb};
   assign nan_in = (&ea) | (&eb);
   assign diff   = ex - ey;

   // Sticky bits are OR-ed, not carried through the add/subtract.
   always_comb begin
      sum_hi = '0;
      if (sx == sy) sum_hi = mx[27:1] + my[27:1];
      else          sum_hi = mx[27:1] - my[27:1];
   end

`ifdef FP_SUB_SEQ_ROUND_EN
   logic        rnd_up;
   logic [24:0] rnd;
   assign rnd_up = mx[2] & (mx[1] | mx[0] | mx[3]);
   assign rnd    = {1'b0, mx[26:3]} + {24'd0, rnd_up};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         sx       <= 1'b0;
         sy       <= 1'b0;
         ex       <= '0;
         ey       <= '0;
         mx       <= '0;
         my       <= '0;
         nan_q    <= 1'b0;
         ovf_q    <= 1'b0;
         flush_q  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         data_r   <= '0;
         overflow <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  sx      <= a_ge ? data_a[31] : ~data_b[31];
                  sy      <= a_ge ? ~data_b[31] : data_a[31];
                  ex      <= a_ge ? ea : eb;
                  ey      <= a_ge ? eb : ea;
                  mx      <= a_ge ? ma : mb;
                  my      <= a_ge ? mb : ma;
                  nan_q   <= nan_in;
                  ovf_q   <= 1'b0;
                  flush_q <= 1'b0;
                  busy    <= 1'b1;
                  state   <= nan_in ? S_PACK : S_ALIGN;
               end
            end
            S_ALIGN: begin
               if (diff == 8'd0) begin
                  state <= S_ADD;
               end else if (diff >= 8'd26) begin
                  my    <= {27'd0, |my};
                  ey    <= ex;
                  state <= S_ADD;
               end else begin
                  my <= {1'b0, my[27:2], my[1] | my[0]};
                  ey <= ey + 8'd1;
                  if (diff == 8'd1) state <= S_ADD;
               end
            end
            S_ADD: begin
               mx    <= {sum_hi, mx[0] | my[0]};
               state <= S_NORM;
            end
            S_NORM: begin
               if (mx == 28'd0) begin
                  sx    <= 1'b0;
                  state <= S_POST;
               end else if (mx[27]) begin
                  mx <= {1'b0, mx[27:2], mx[1] | mx[0]};
                  ex <= ex + 8'd1;
                  if (ex == 8'd254) ovf_q <= 1'b1;
                  state <= S_POST;
               end else if (mx[26]) begin
                  state <= S_POST;
               end else if (ex == 8'd1) begin
                  flush_q <= 1'b1;
                  ex      <= 8'd0;
                  state   <= S_POST;
               end else begin
                  mx <= {mx[26:0], 1'b0};
                  ex <= ex - 8'd1;
                  if (mx[25]) state <= S_POST;
               end
            end
`ifdef FP_SUB_SEQ_ROUND_EN
            S_ROUND: begin
               if (!ovf_q && !flush_q && mx != 28'd0) begin
                  if (rnd[24]) begin
                     mx <= {1'b0, rnd[24:1], 3'b000};
                     ex <= ex + 8'd1;
                     if (ex == 8'd254) ovf_q <= 1'b1;
                  end else begin
                     mx <= {1'b0, rnd[23:0], 3'b000};
                  end
               end
               state <= S_PACK;
            end
`endif
            S_PACK: begin
               if (nan_q)             data_r <= 32'h7FC00000;
               else if (ovf_q)        data_r <= {sx, 8'hFF, 23'd0};
               else if (flush_q)      data_r <= {sx, 31'd0};
               else if (mx == 28'd0)  data_r <= 32'd0;
               else                   data_r <= {sx, ex, mx[25:3]};
               overflow <= ovf_q & ~nan_q;
               done     <= 1'b1;
               state    <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_sub_seq.sv
// tb_fp_sub_seq: vector table, corner sequences and randomized
// operands against an arithmetic reference model for fp_sub_seq.
module tb_fp_sub_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] data_a = '0;
   logic [31:0] data_b = '0;
   logic        busy, done, overflow;
   logic [31:0] data_r;

   int checks = 0;
   int errors = 0;

   fp_sub_seq dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .data_a(data_a), .data_b(data_b),
      .busy(busy), .done(done),
      .data_r(data_r), .overflow(overflow)
   );

   always #5 clk = ~clk;

`ifdef FP_SUB_SEQ_ROUND_EN
   localparam int MIN_LAT = 6;
`else
   localparam int MIN_LAT = 5;
`endif

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Reference: aligned magnitudes as integers, sticky kept as a
   // separate OR bit, normalisation by loop, optional RNE.
   function automatic logic [32:0] ref_sub(input logic [31:0] a,
                                           input logic [31:0] b);
      longint ea, eb, fa, fb, ma, mb, mx, my, r, m, ex, d, ey;
      logic   sa, sb, sx, sy, g, rs, lsb;
      ea = longint'(a[30:23]);
      eb = longint'(b[30:23]);
      if (ea == 255 || eb == 255) return {1'b0, 32'h7FC00000};
      fa = (ea == 0) ? 0 : longint'(a[22:0]);
      fb = (eb == 0) ? 0 : longint'(b[22:0]);
      ma = (ea == 0) ? 0 : ((64'd1 << 23) + fa) * 8;
      mb = (eb == 0) ? 0 : ((64'd1 << 23) + fb) * 8;
      sa = a[31];
      sb = ~b[31];
      if (ea * (64'd1 << 23) + fa >= eb * (64'd1 << 23) + fb) begin
         sx = sa; sy = sb; ex = ea; ey = eb; mx = ma; my = mb;
      end else begin
         sx = sb; sy = sa; ex = eb; ey = ea; mx = mb; my = ma;
      end
      d = ex - ey;
      if (d >= 26) my = (my != 0) ? 1 : 0;
      else my = ((my >> d) & ~64'd1)
                | (((my & ((64'd1 << (d + 1)) - 1)) != 0) ? 1 : 0);
      if (sx == sy) r = (((mx >> 1) + (my >> 1)) << 1) | ((mx | my) & 1);
      else          r = (((mx >> 1) - (my >> 1)) << 1) | ((mx | my) & 1);
      if (r == 0) return 33'd0;
      if (((r >> 27) & 1) != 0) begin
         r = ((r >> 1) & ~64'd1) | (((r & 3) != 0) ? 1 : 0);
         ex++;
         if (ex >= 255) return {1'b1, sx, 8'hFF, 23'd0};
      end else begin
         while (((r >> 26) & 1) == 0) begin
            r = r << 1;
            ex--;
            if (ex == 0) return {1'b0, sx, 31'd0};
         end
      end
`ifdef FP_SUB_SEQ_ROUND_EN
      g   = ((r >> 2) & 1) != 0;
      rs  = (r & 3) != 0;
      lsb = ((r >> 3) & 1) != 0;
      m   = r >> 3;
      if (g && (rs || lsb)) m++;
      if ((m >> 24) != 0) begin
         m = m >> 1;
         ex++;
         if (ex >= 255) return {1'b1, sx, 8'hFF, 23'd0};
      end
      r = m << 3;
`else
      g = 0; rs = 0; lsb = 0; m = 0;
`endif
      return {1'b0, sx, ex[7:0], r[25:3]};
   endfunction

   // One operation; poke>0 pulses start with other operands mid-flight.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input int poke, output logic [31:0] r,
                         output logic ov, output int lat);
      @(posedge clk); #1;
      data_a = a; data_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 70) begin
         if (lat == poke) begin
            start = 1'b1; data_a = 32'h40600000; data_b = 32'h40400000;
         end else start = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL timeout actual=no_done required=done");
      end
      r  = data_r;
      ov = overflow;
      chk("busy_at_done", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      chk("done_pulse", {31'd0, done}, 32'd0);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("r_hold", data_r, r);
   endtask

   typedef struct {
      logic [31:0] a, b, r;
      logic        ov;
      int          poke;
   } vec_t;

   vec_t        tbl[12];
   logic [31:0] r, a, b;
   logic        ov;
   int          lat, extra;
   logic [32:0] exp_v;
   logic [7:0]  eb;

   initial begin
      tbl[0]  = '{32'h40600000, 32'h40400000, 32'h3F000000, 1'b0, 0};
      tbl[1]  = '{32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 0};
      tbl[2]  = '{32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 0};
      tbl[3]  = '{32'h3F800000, 32'h30800000, 32'h3F800000, 1'b0, 0};
      tbl[4]  = '{32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 3};
      tbl[5]  = '{32'hFF7FFFFF, 32'h7F7FFFFF, 32'hFF800000, 1'b1, 0};
      tbl[6]  = '{32'h7F800000, 32'h3F800000, 32'h7FC00000, 1'b0, 0};
      tbl[7]  = '{32'h3F800000, 32'h7FC00000, 32'h7FC00000, 1'b0, 0};
      tbl[8]  = '{32'h00000001, 32'h00000001, 32'h00000000, 1'b0, 0};
      tbl[9]  = '{32'h00C00000, 32'h00800000, 32'h00000000, 1'b0, 0};
      tbl[10] = '{32'h80C00000, 32'h80800000, 32'h80000000, 1'b0, 0};
      tbl[11] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0, 0};

      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_r", data_r, 32'd0);
      chk("rst_ov", {31'd0, overflow}, 32'd0);
      #11 rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].poke, r, ov, lat);
         chk($sformatf("vec%0d_r", i), r, tbl[i].r);
         chk($sformatf("vec%0d_ov", i), {31'd0, ov}, {31'd0, tbl[i].ov});
         chk($sformatf("vec%0d_lat", i), {31'd0, lat <= 58}, 32'd1);
         if (i == 1) chk("lat_min", lat, MIN_LAT);
         if (tbl[i].poke != 0) begin
            extra = 0;
            for (int k = 0; k < 10; k++) begin
               @(posedge clk); #1;
               if (done) extra++;
            end
            chk("ignored_start", extra, 0);
            chk("ignored_r", data_r, tbl[i].r);
         end
      end

      // Reset while ALIGN is shifting (1.0 - 2^-20).
      @(posedge clk); #1;
      data_a = 32'h3F800000; data_b = 32'h35800000; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("mid_busy", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_r", data_r, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_op(32'h40600000, 32'h40400000, 0, r, ov, lat);
      chk("post_rst_r", r, 32'h3F000000);

      for (int i = 0; i < 300; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 2 == 0) begin
            eb = a[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
            b[30:23] = eb;
         end
         exp_v = ref_sub(a, b);
         run_op(a, b, 0, r, ov, lat);
         chk($sformatf("rnd%0d_r %h-%h", i, a, b), r, exp_v[31:0]);
         chk($sformatf("rnd%0d_ov", i), {31'd0, ov}, {31'd0, exp_v[32]});
         chk($sformatf("rnd%0d_lat", i), {31'd0, lat <= 58}, 32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_sub_seq.md
FP_SUB_SEQ -- requirements
Module: fp_sub_seq

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  The single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  Asynchronous active-low reset.
REQ-004 start  input  1  Operand-valid request; sampled only in IDLE.
REQ-005 data_a  input  32  Minuend A, IEEE-754 single precision.
REQ-006 data_b  input  32  Subtrahend B, IEEE-754 single precision.
REQ-007 busy  output  1  High from the cycle after acceptance until the DONE cycle, inclusive.
REQ-008 done  output  1  One-cycle pulse; data_r is valid in this cycle.
REQ-009 data_r  output  32  Result R = A - B, IEEE-754 single precision.
REQ-010 overflow  output  1  Set with done when the result saturated to infinity.

Function
REQ-011 FSM states SHALL be IDLE, ALIGN, ADD, NORM, [ROUND], PACK, DONE; DONE SHALL always return to IDLE.
REQ-012 In IDLE, start=1 SHALL latch data_a and data_b and go to ALIGN; start while busy SHALL be ignored.
REQ-013 The effective operation SHALL be A + (-B): the latched sign of B is inverted.
REQ-014 Exponent field 0 SHALL be treated as zero: hidden bit 0, fraction forced to 0, so denormals are flushed.
REQ-015 Exponent field 255 on either operand SHALL bypass to PACK with data_r=32'h7FC00000 and overflow=0.
REQ-016 Mantissa datapath: 28 bits = carry, hidden, 23 fraction, guard, round, sticky.
REQ-017 ALIGN: operands are ordered so that X has the larger magnitude; the smaller mantissa shifts right 1 bit/cycle (exponent +1) until the exponents are equal; shifted-out bits OR into sticky.
REQ-018 ALIGN: an exponent difference >=26 SHALL zero the smaller mantissa, keep sticky=1 if it was nonzero, and complete in one cycle.
REQ-019 ADD (1 cycle): equal signs add magnitudes; differing signs subtract smaller from larger; result sign = sign of X.
REQ-020 An exact zero difference SHALL yield +0 (32'h00000000).
REQ-021 NORM: carry=1 -> shift right once, exponent +1, LSB kept in sticky; else shift left 1 bit/cycle, exponent -1, while hidden=0 and mantissa!=0.
REQ-022 Exponent reaching 0 during NORM SHALL flush the result to signed zero.
REQ-023 Exponent reaching 255 SHALL give data_r = {sign, 8'hFF, 23'h0} and overflow=1.
REQ-024 Worst-case latency from start to done SHALL be <=58 cycles; the minimum latency SHALL be 5 cycles without ROUND.
REQ-025 done SHALL be high for exactly one cycle; data_r and overflow SHALL hold until the next done.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, overflow=0, data_r=0 and clear all internal registers, including mid-operation.
REQ-027 Following reset release, the first start SHALL be accepted on the first rising clk edge.

Configuration
REQ-028 When macro FP_SUB_SEQ_ROUND_EN is defined, the ROUND state (1 cycle) SHALL apply round-to-nearest-even using guard/round/sticky, with a renormalising shift and exponent +1 on mantissa carry-out.
REQ-029 When FP_SUB_SEQ_ROUND_EN is undefined, the ROUND state SHALL be absent and the result SHALL be truncated (guard/round/sticky discarded).

Verification
REQ-030 A=32'h40600000 (3.5), B=32'h40400000 (3.0), start 1 cycle -> one done pulse, data_r=32'h3F000000, overflow=0.
REQ-031 A=B=32'h3F800000 -> data_r=32'h00000000.
REQ-032 A=32'h3F800000, B=32'hBF800000 -> data_r=32'h40000000 (2.0).
REQ-033 A=32'h3F800000, B=32'h30800000 (2^-30) -> ALIGN finishes in 1 cycle; data_r=32'h3F800000 in both macro builds.
REQ-034 A=32'h7F7FFFFF, B=32'hFF7FFFFF -> data_r=32'h7F800000, overflow=1; a second start pulse while busy leaves the result unchanged.
REQ-035 Drive rst_n=0 during ALIGN -> busy=0, done=0, data_r=0 with no clock edge; after release, a new 3.5-3.0 operation returns 32'h3F000000.
